// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges fixed-latency pipeline results (P) and buffered
// long-latency results (L, via FIFO) onto the single regfile write port.
// Ports:
//   clk, reset                 clock, async active-high reset
//   p_valid/p_addr/p_data      pipeline result, always accepted
//   l_valid/l_ready/l_addr/l_data  long-latency result into FIFO
//   stall                      asks upstream to hold p_valid low
//   q_addr_a/b, hit_a/b        pending-write query for decode
//   wrd/addr_d/d               registered regfile write
//   fifo_count                 FIFO occupancy
//   err                        sticky: p_valid seen during stall
module wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_valid,
  input  logic [4:0]             p_addr,
  input  logic [DATA_W-1:0]      p_data,
  input  logic                   l_valid,
  output logic                   l_ready,
  input  logic [4:0]             l_addr,
  input  logic [DATA_W-1:0]      l_data,
  output logic                   stall,
  input  logic [4:0]             q_addr_a,
  input  logic [4:0]             q_addr_b,
  output logic                   hit_a,
  output logic                   hit_b,
  output logic                   wrd,
  output logic [4:0]             addr_d,
  output logic [DATA_W-1:0]      d,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [4:0]        mem_a [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [WW-1:0]     wait_cnt;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              take_p;

  assign empty      = (cnt == '0);
  assign full       = (cnt == FULL_CNT);
  assign l_ready    = !full;
  assign fifo_count = cnt;
  assign stall      = (wait_cnt == WMAX) && !empty;

  // x0 writes complete the handshake but are never stored.
  assign push = l_valid && !full && (l_addr != 5'd0);

  always_comb begin
    pop    = 1'b0;
    take_p = 1'b0;
    priority case (1'b1)
      stall:                       pop    = 1'b1;
      p_valid && (p_addr != 5'd0): take_p = 1'b1;
      !empty:                      pop    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem_a[i] == q_addr_a)) hit_a = 1'b1;
      if (vld[i] && (mem_a[i] == q_addr_b)) hit_b = 1'b1;
    end
    if (wrd && (addr_d == q_addr_a)) hit_a = 1'b1;
    if (wrd && (addr_d == q_addr_b)) hit_b = 1'b1;
    if (q_addr_a == 5'd0) hit_a = 1'b0;
    if (q_addr_b == 5'd0) hit_b = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= l_addr;
      mem_d[wr_ptr] <= l_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      vld      <= '0;
      wait_cnt <= '0;
      wrd      <= 1'b0;
      addr_d   <= '0;
      d        <= '0;
      err      <= 1'b0;
    end else begin
      // rd_ptr == wr_ptr with both active only when full, which blocks push.
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + 1'b1;
      if (pop) begin
        wrd    <= 1'b1;
        addr_d <= mem_a[rd_ptr];
        d      <= mem_d[rd_ptr];
      end else if (take_p) begin
        wrd    <= 1'b1;
        addr_d <= p_addr;
        d      <= p_data;
      end else begin
        wrd    <= 1'b0;
      end
      err <= err | (stall & p_valid);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected regfile writes
// plus direct checks of occupancy, stall, hazard hits and err.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic        stall;
  logic [4:0]  q_addr_a;
  logic [4:0]  q_addr_b;
  logic        hit_a;
  logic        hit_b;
  logic        wrd;
  logic [4:0]  addr_d;
  logic [31:0] d;
  logic [2:0]  fifo_count;
  logic        err;

  int n_chk = 0;
  int n_bad = 0;

  logic [36:0] exp_q[$];
  logic [36:0] lq[$];

  wb_arbiter #(.DEPTH(4), .MAX_WAIT(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
    .l_valid(l_valid), .l_ready(l_ready),
    .l_addr(l_addr), .l_data(l_data),
    .stall(stall),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
    .hit_a(hit_a), .hit_b(hit_b),
    .wrd(wrd), .addr_d(addr_d), .d(d),
    .fifo_count(fifo_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (wrd) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", {59'd0, addr_d}, 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("sb_addr", {59'd0, addr_d}, {59'd0, e[36:32]});
        chk("sb_data", {32'd0, d}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid = 1'b0;
    p_addr  = '0;
    p_data  = '0;
    l_valid = 1'b0;
    l_addr  = '0;
    l_data  = '0;
  endtask

  task automatic drive_p(input logic [4:0] a, input logic [31:0] v);
    p_valid = 1'b1;
    p_addr  = a;
    p_data  = v;
    exp_q.push_back({a, v});
  endtask

  // One cycle with P occupying the write slot while L pushes.
  task automatic push_cycle(input logic [4:0] a, input logic [31:0] v);
    drive_p(5'd1, {16'h7000, 11'd0, a});
    l_valid = 1'b1;
    l_addr  = a;
    l_data  = v;
    lq.push_back({a, v});
    tick();
  endtask

  task automatic expect_l();
    exp_q.push_back(lq.pop_front());
  endtask

  initial begin
    logic [36:0] h;
    reset    = 1'b1;
    q_addr_a = '0;
    q_addr_b = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_wrd", {63'd0, wrd}, 64'd0);
    chk("rst_cnt", {61'd0, fifo_count}, 64'd0);
    chk("rst_rdy", {63'd0, l_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_addr", {59'd0, addr_d}, 64'd0);

    // single P write
    q_addr_a = 5'd5;
    drive_p(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    chk("p_wrd", {63'd0, wrd}, 64'd1);
    chk("p_addr", {59'd0, addr_d}, 64'd5);
    chk("p_data", {32'd0, d}, 64'hDEADBEEF);
    chk("p_hit", {63'd0, hit_a}, 64'd1);
    tick();
    chk("p_wrd_off", {63'd0, wrd}, 64'd0);
    chk("p_hit_off", {63'd0, hit_a}, 64'd0);

    // fill FIFO with 3,4,7,9 then drain in order
    push_cycle(5'd3, 32'h33);
    push_cycle(5'd4, 32'h44);
    push_cycle(5'd7, 32'h77);
    push_cycle(5'd9, 32'h99);
    idle();
    q_addr_a = 5'd7;
    q_addr_b = 5'd8;
    #1;
    chk("f_cnt4", {61'd0, fifo_count}, 64'd4);
    chk("f_rdy0", {63'd0, l_ready}, 64'd0);
    chk("f_hit7", {63'd0, hit_a}, 64'd1);
    chk("f_hit8", {63'd0, hit_b}, 64'd0);
    for (int i = 0; i < 4; i++) expect_l();
    tick();
    chk("dr_cnt3", {61'd0, fifo_count}, 64'd3);
    chk("dr_a3", {59'd0, addr_d}, 64'd3);
    tick();
    chk("dr_a4", {59'd0, addr_d}, 64'd4);
    tick();
    chk("dr_a7", {59'd0, addr_d}, 64'd7);
    chk("dr_hit7", {63'd0, hit_a}, 64'd1);
    tick();
    chk("dr_a9", {59'd0, addr_d}, 64'd9);
    chk("dr_hit7c", {63'd0, hit_a}, 64'd0);
    chk("dr_cnt0", {61'd0, fifo_count}, 64'd0);
    tick();
    chk("dr_idle", {63'd0, wrd}, 64'd0);

    // starvation: one entry, P continuous
    for (int i = 0; i < 9; i++) begin
      drive_p(5'd2, 32'h100 + i);
      if (i == 0) begin
        l_valid = 1'b1;
        l_addr  = 5'd12;
        l_data  = 32'hC0C0;
        lq.push_back({5'd12, 32'hC0C0});
      end
      tick();
      l_valid = 1'b0;
      if (i == 7) chk("sv_stall0", {63'd0, stall}, 64'd0);
      if (i == 8) chk("sv_stall1", {63'd0, stall}, 64'd1);
    end
    chk("sv_err0", {63'd0, err}, 64'd0);
    p_valid = 1'b1;
    p_addr  = 5'd2;
    p_data  = 32'hBAD;
    expect_l();
    tick();
    idle();
    chk("sv_a12", {59'd0, addr_d}, 64'd12);
    chk("sv_unstall", {63'd0, stall}, 64'd0);
    chk("sv_err1", {63'd0, err}, 64'd1);
    chk("sv_cnt0", {61'd0, fifo_count}, 64'd0);
    tick();

    // full FIFO: pop and l_valid in same cycle, push refused
    push_cycle(5'd10, 32'hA0);
    push_cycle(5'd11, 32'hB0);
    push_cycle(5'd13, 32'hD0);
    push_cycle(5'd14, 32'hE0);
    idle();
    l_valid = 1'b1;
    l_addr  = 5'd20;
    l_data  = 32'h2020;
    #1;
    chk("fu_rdy0", {63'd0, l_ready}, 64'd0);
    for (int i = 0; i < 4; i++) expect_l();
    tick();
    l_valid = 1'b0;
    chk("fu_cnt3", {61'd0, fifo_count}, 64'd3);
    tick();
    tick();
    tick();
    chk("fu_cnt0", {61'd0, fifo_count}, 64'd0);
    tick();

    // x0 on both ports: no enqueue, no P slot, FIFO drains
    push_cycle(5'd15, 32'hF0);
    idle();
    l_valid = 1'b1;
    l_addr  = 5'd0;
    l_data  = 32'h1;
    p_valid = 1'b1;
    p_addr  = 5'd0;
    p_data  = 32'h2;
    #1;
    chk("z_rdy", {63'd0, l_ready}, 64'd1);
    expect_l();
    tick();
    chk("z_a15", {59'd0, addr_d}, 64'd15);
    chk("z_cnt0", {61'd0, fifo_count}, 64'd0);
    tick();
    chk("z_nowr", {63'd0, wrd}, 64'd0);
    chk("z_cnt0b", {61'd0, fifo_count}, 64'd0);
    idle();
    tick();

    // async reset mid-drain with 3 entries left
    push_cycle(5'd16, 32'h160);
    push_cycle(5'd17, 32'h170);
    push_cycle(5'd18, 32'h180);
    push_cycle(5'd19, 32'h190);
    idle();
    tick();
    h = lq.pop_front();
    chk("md_a16", {59'd0, addr_d}, {59'd0, h[36:32]});
    chk("md_cnt3", {61'd0, fifo_count}, 64'd3);
    lq.delete();
    #1;
    reset = 1'b1;
    #1;
    chk("md_wrd", {63'd0, wrd}, 64'd0);
    chk("md_cnt", {61'd0, fifo_count}, 64'd0);
    chk("md_stall", {63'd0, stall}, 64'd0);
    chk("md_rdy", {63'd0, l_ready}, 64'd1);
    chk("md_err", {63'd0, err}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("md_post_wrd", {63'd0, wrd}, 64'd0);
    chk("md_post_cnt", {61'd0, fifo_count}, 64'd0);

    chk("sb_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
